sort_sequencer: RTL
===================

Name: sort_sequencer

Overview:
- Controller and buffer for the odd-even transposition sort datapath of the sorting accelerator.
- Accepts a frame of up to DEPTH keys on a valid/ready input stream and holds them in an internal register array.
- Sequences DEPTH compare-exchange phases, one phase per clock, then streams the sorted frame out on a valid/ready output stream.
- Sits between the board-level input path (ulx3s top) and the result output path.

Parameters:
- WIDTH, 8, key width in bits.
- DEPTH, 8, maximum keys per frame; must be even and >= 2.
- DESCENDING, 0, 0 = ascending output order, 1 = descending.

Ports:
- clk_i  input  1  system clock, rising-edge.
- rst_i  input  1  asynchronous reset, active-high.
- in_data_i  input  WIDTH  key to load.
- in_valid_i  input  1  in_data_i is valid.
- in_last_i  input  1  final key of the frame; qualified by in_valid_i.
- in_ready_o  output  1  block can accept a key (state LOAD).
- out_data_o  output  WIDTH  sorted key.
- out_valid_o  output  1  out_data_o is valid (state DRAIN).
- out_ready_i  input  1  consumer accepts out_data_o.
- out_last_o  output  1  final key of the frame; qualified by out_valid_o.
- busy_o  output  1  high in SORT or DRAIN.
- phase_o  output  $clog2(DEPTH)  current sort phase index; 0 outside SORT.

Behaviour:
- Reset values: in_ready_o=1, out_valid_o=0, out_last_o=0, busy_o=0, phase_o=0, out_data_o=0. All slots are marked empty and the state is LOAD. Reset asserted at any time, including mid-SORT or mid-DRAIN, aborts the frame with no partial output.
- Handshake: a transfer occurs on a rising edge where valid && ready are both high. Valid and data are held stable until the transfer. out_valid_o and out_data_o never depend combinationally on out_ready_i.
- Each slot stores {empty flag, key}. An empty slot compares as greater than any key in ascending mode and as smaller than any key in descending mode, so empty slots always sort to the tail.
- FSM LOAD:
  - Each accepted key is written to slot cnt, the slot is marked full, and cnt increments.
  - Leave for SORT on the accept edge if in_last_i=1 or cnt reaches DEPTH, i.e. the DEPTH-th key ends the frame even if in_last_i=0.
  - Frame length L = number of accepted keys, 1..DEPTH.
- FSM SORT:
  - in_ready_o=0.
  - Phase p runs from 0 to DEPTH-1, one phase per edge.
  - Even p compare-exchanges slot pairs (0,1),(2,3),...
  - Odd p compare-exchanges pairs (1,2),(3,4),...; slots 0 and DEPTH-1 are untouched in odd phases.
  - A pair swaps only if it is strictly out of order; equal keys are never swapped.
  - The edge that executes phase DEPTH-1 also enters DRAIN.
- Latency: out_valid_o rises exactly DEPTH edges after the edge that accepted the final key, independent of L and of the data.
- FSM DRAIN:
  - Output slot rd for rd = 0..L-1, advancing on each output transfer.
  - out_last_o=1 when rd = L-1.
  - The transfer with out_last_o=1 clears all slots, sets cnt=0 and returns to LOAD, so in_ready_o=1 on the next cycle.
  - Empty slots are never output.
- Inputs are ignored outside LOAD. in_valid_i during SORT or DRAIN is not accepted and not lost; the source holds it.
- L=1 is legal: SORT still takes DEPTH cycles.

Test Plan:
- Reset check: assert rst_i asynchronously between edges -> outputs take reset values immediately; after release in_ready_o=1, out_valid_o=0, busy_o=0.
- Full frame, DEPTH=8: load 5,3,7,1,8,2,6,4 with in_last_i on the 8th key -> out_valid_o rises 8 edges after the final accept; output 1,2,3,4,5,6,7,8 with out_last_o only on 8; phase_o steps 0..7 during SORT.
- Short frame: load 9,0,9 with in_last_i on the 3rd key -> output 0,9,9 with out_last_o on the 3rd key, exactly 3 transfers; in_ready_o=1 on the cycle after.
- Worst case plus backpressure: load 8,7,6,5,4,3,2,1 while toggling out_ready_i 1,0,0,1,... -> output 1..8, each value held stable while stalled, no duplicates or drops.
- DESCENDING=1, DEPTH=8: load 2,255,0,17 with last -> output 255,17,2,0.
- Reset mid-operation: assert rst_i at SORT phase 3 -> busy_o=0, out_valid_o=0, no output. A new frame 4,1 then yields 1,4.

Source files
------------

// File: rtl/sort_sequencer.sv
// Frame buffer and sequencer for the odd-even transposition sorter.
// Loads up to DEPTH keys, runs DEPTH compare-exchange phases, then drains.
module sort_sequencer #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter bit DESCENDING = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     in_valid_i,
  input  logic                     in_last_i,
  output logic                     in_ready_o,
  output logic [WIDTH-1:0]         out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_last_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH)-1:0] phase_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] key_q [DEPTH];
  logic [WIDTH-1:0] key_d [DEPTH];
  logic [DEPTH-1:0] empty_q, empty_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    phase_q, phase_d;

  // Empty slots always lose toward the tail, whatever the direction.
  function automatic logic out_of_order(
    input logic             ea,
    input logic [WIDTH-1:0] ka,
    input logic             eb,
    input logic [WIDTH-1:0] kb
  );
    if (eb) return 1'b0;
    if (ea) return 1'b1;
    return DESCENDING ? (ka < kb) : (ka > kb);
  endfunction

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    empty_d     = empty_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    phase_d     = phase_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_data_o  = '0;
    busy_o      = 1'b0;
    phase_o     = '0;
    unique case (state_q)
      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          key_d[cnt_q[PW-1:0]]   = in_data_i;
          empty_d[cnt_q[PW-1:0]] = 1'b0;
          cnt_d = cnt_q + CW'(1);
          if (in_last_i || cnt_q == CW'(DEPTH - 1)) begin
            state_d = SORT;
            phase_d = '0;
          end
        end
      end
      SORT: begin
        busy_o  = 1'b1;
        phase_o = phase_q;
        // Pairs start on even slots in even phases, odd slots in odd ones.
        for (int i = 0; i < DEPTH - 1; i++) begin
          if ((((i % 2) == 1) == phase_q[0]) &&
              out_of_order(empty_q[i], key_q[i],
                           empty_q[i+1], key_q[i+1])) begin
            key_d[i]     = key_q[i+1];
            key_d[i+1]   = key_q[i];
            empty_d[i]   = empty_q[i+1];
            empty_d[i+1] = empty_q[i];
          end
        end
        phase_d = phase_q + PW'(1);
        if (phase_q == PW'(DEPTH - 1)) begin
          state_d = DRAIN;
          phase_d = '0;
          rd_d    = '0;
        end
      end
      DRAIN: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        out_data_o  = key_q[rd_q];
        out_last_o  = (CW'(rd_q) == cnt_q - CW'(1));
        if (out_ready_i) begin
          rd_d = rd_q + PW'(1);
          if (out_last_o) begin
            for (int i = 0; i < DEPTH; i++) key_d[i] = '0;
            empty_d = '1;
            cnt_d   = '0;
            rd_d    = '0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      for (int i = 0; i < DEPTH; i++) key_q[i] <= '0;
      empty_q <= '1;
      cnt_q   <= '0;
      rd_q    <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      empty_q <= empty_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      phase_q <= phase_d;
    end
  end

endmodule
